clk_div_n: RTL and testbench

CLK_DIV_N -- requirements
Module: clk_div_n

---
 rtl/clk_div_n.sv | 86 ++++++++
 tb/tb_clk_div_n.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - programmable integer clock divider with glitch-free divisor reload
// Square or pulse output; new divisors are applied only at period boundaries.
module clk_div_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] div_cur
);

  logic             running;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pending;

  logic             wrap;
  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH:0]   half;
  logic             level_nx;

  always_comb begin
    wrap     = (cnt == div_cur - WIDTH'(1));
    cnt_nx   = wrap ? '0 : cnt + WIDTH'(1);
    ld_val   = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
    half     = ({1'b0, div_cur} + (WIDTH+1)'(1)) >> 1;
    // a wrap always yields cnt_nx=0, which is high under any divisor, so the
    // pre-update div_cur is safe to use for the level decision
    level_nx = mode ? (cnt_nx == '0) : ({1'b0, cnt_nx} < half);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      div_cur <= WIDTH'(DEFAULT_DIV);
      pending <= WIDTH'(DEFAULT_DIV);
      busy    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!en) begin
      running <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
      if (load) begin
        div_cur <= ld_val;
      end else if (busy) begin
        div_cur <= pending;
      end
    end else if (!running) begin
      running <= 1'b1;
      cnt     <= '0;
      clk_out <= 1'b1;
      tick    <= 1'b1;
      if (load) begin
        div_cur <= ld_val;
        busy    <= 1'b0;
      end
    end else begin
      cnt     <= cnt_nx;
      clk_out <= level_nx;
      tick    <= (cnt_nx == '0);
      if (wrap) begin
        busy <= 1'b0;
        if (load) begin
          div_cur <= ld_val;
        end else if (busy) begin
          div_cur <= pending;
        end
      end else if (load) begin
        pending <= ld_val;
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_n.sv
// tb/tb_clk_div_n.sv - scoreboard bench for clk_div_n
// Stimulus pushes hand-computed per-edge expectations; a monitor pops and compares.
module tb_clk_div_n;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       en     = 1'b0;
  logic       mode   = 1'b0;
  logic       load   = 1'b0;
  logic [7:0] div_in = 8'd0;
  logic       clk_out;
  logic       tick;
  logic       busy;
  logic [7:0] div_cur;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic [7:0] div_cur;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  clk_div_n #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .div_in  (div_in),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy),
    .div_cur (div_cur)
  );

  always #5 clk_in = ~clk_in;

  // monitor: one expectation is consumed per edge that the stimulus described
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (clk_out !== e.clk_out) begin
          errors++;
          $display("FAIL %s clk_out: got %b want %b", e.name, clk_out, e.clk_out);
        end
        checks++;
        if (tick !== e.tick) begin
          errors++;
          $display("FAIL %s tick: got %b want %b", e.name, tick, e.tick);
        end
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL %s busy: got %b want %b", e.name, busy, e.busy);
        end
        checks++;
        if (div_cur !== e.div_cur) begin
          errors++;
          $display("FAIL %s div_cur: got %0d want %0d", e.name, div_cur, e.div_cur);
        end
      end
    end
  end

  task automatic step(input logic r, input logic e_n, input logic m, input logic l,
                      input logic [7:0] d, input logic ec, input logic et,
                      input logic eb, input logic [7:0] ed, input string nm);
    exp_t x;
    @(negedge clk_in);
    reset  = r;
    en     = e_n;
    mode   = m;
    load   = l;
    div_in = d;
    x.clk_out = ec;
    x.tick    = et;
    x.busy    = eb;
    x.div_cur = ed;
    x.name    = nm;
    exp_q.push_back(x);
  endtask

  initial begin
    // reset state
    step(1, 0, 0, 0, 0,   0, 0, 0, 2, "rst0");
    step(1, 1, 0, 1, 9,   0, 0, 0, 2, "rst_override");

    // N=2 square
    step(0, 1, 0, 0, 0,   1, 1, 0, 2, "n2_start");
    step(0, 1, 0, 0, 0,   0, 0, 0, 2, "n2_c1");
    step(0, 1, 0, 0, 0,   1, 1, 0, 2, "n2_c2");
    step(0, 1, 0, 0, 0,   0, 0, 0, 2, "n2_c3");
    step(0, 0, 0, 0, 0,   0, 0, 0, 2, "idle0");

    // load 5 while idle, odd duty 3/2
    step(0, 0, 0, 1, 5,   0, 0, 0, 5, "n5_load_idle");
    step(0, 1, 0, 0, 0,   1, 1, 0, 5, "n5_start");
    step(0, 1, 0, 0, 0,   1, 0, 0, 5, "n5_c1");
    step(0, 1, 0, 0, 0,   1, 0, 0, 5, "n5_c2");
    step(0, 1, 0, 0, 0,   0, 0, 0, 5, "n5_c3");
    step(0, 1, 0, 0, 0,   0, 0, 0, 5, "n5_c4");
    step(0, 1, 0, 0, 0,   1, 1, 0, 5, "n5_wrap");
    step(0, 1, 0, 0, 0,   1, 0, 0, 5, "n5_c1b");
    step(0, 0, 0, 0, 0,   0, 0, 0, 5, "idle1");

    // N=4 running, load 6 mid-period
    step(0, 0, 0, 1, 4,   0, 0, 0, 4, "n4_load_idle");
    step(0, 1, 0, 0, 0,   1, 1, 0, 4, "n4_start");
    step(0, 1, 0, 1, 6,   1, 0, 1, 4, "n4_load6");
    step(0, 1, 0, 0, 0,   0, 0, 1, 4, "n4_c2");
    step(0, 1, 0, 0, 0,   0, 0, 1, 4, "n4_c3");
    step(0, 1, 0, 0, 0,   1, 1, 0, 6, "n6_wrap");
    step(0, 1, 0, 0, 0,   1, 0, 0, 6, "n6_c1");
    step(0, 1, 0, 0, 0,   1, 0, 0, 6, "n6_c2");
    step(0, 1, 0, 0, 0,   0, 0, 0, 6, "n6_c3");
    step(0, 1, 0, 0, 0,   0, 0, 0, 6, "n6_c4");
    step(0, 1, 0, 0, 0,   0, 0, 0, 6, "n6_c5");
    step(0, 1, 0, 0, 0,   1, 1, 0, 6, "n6_wrap2");
    step(0, 0, 0, 0, 0,   0, 0, 0, 6, "idle2");

    // last pending value wins
    step(0, 0, 0, 1, 4,   0, 0, 0, 4, "lw_load_idle");
    step(0, 1, 0, 0, 0,   1, 1, 0, 4, "lw_start");
    step(0, 1, 0, 1, 7,   1, 0, 1, 4, "lw_load7");
    step(0, 1, 0, 1, 3,   0, 0, 1, 4, "lw_load3");
    step(0, 1, 0, 0, 0,   0, 0, 1, 4, "lw_c3");
    step(0, 1, 0, 0, 0,   1, 1, 0, 3, "n3_wrap");
    step(0, 1, 0, 0, 0,   1, 0, 0, 3, "n3_c1");
    step(0, 1, 0, 0, 0,   0, 0, 0, 3, "n3_c2");
    step(0, 1, 0, 0, 0,   1, 1, 0, 3, "n3_wrap2");
    step(0, 1, 0, 0, 0,   1, 0, 0, 3, "n3_c1b");
    step(0, 1, 0, 0, 0,   0, 0, 0, 3, "n3_c2b");
    // load on the wrap edge goes straight to div_cur
    step(0, 1, 0, 1, 5,   1, 1, 0, 5, "wrap_load5");
    step(0, 1, 0, 0, 0,   1, 0, 0, 5, "wl_c1");
    step(0, 0, 0, 0, 0,   0, 0, 0, 5, "idle3");

    // clamps, then mode 1 with N=3
    step(0, 0, 0, 1, 0,   0, 0, 0, 2, "clamp0");
    step(0, 0, 0, 1, 1,   0, 0, 0, 2, "clamp1");
    step(0, 0, 1, 1, 3,   0, 0, 0, 3, "m1_load3");
    step(0, 1, 1, 0, 0,   1, 1, 0, 3, "m1_start");
    step(0, 1, 1, 0, 0,   0, 0, 0, 3, "m1_c1");
    step(0, 1, 1, 0, 0,   0, 0, 0, 3, "m1_c2");
    step(0, 1, 1, 0, 0,   1, 1, 0, 3, "m1_wrap");
    step(0, 1, 1, 0, 0,   0, 0, 0, 3, "m1_c1b");
    // mode change without cnt reset
    step(0, 1, 0, 0, 0,   0, 0, 0, 3, "mc_c2");
    step(0, 1, 0, 0, 0,   1, 1, 0, 3, "mc_wrap");
    step(0, 1, 0, 0, 0,   1, 0, 0, 3, "mc_c1");
    // pending flushed on idle entry
    step(0, 1, 0, 1, 7,   0, 0, 1, 3, "pend_load7");
    step(0, 0, 0, 0, 0,   1'b0, 0, 0, 7, "pend_flush");

    // load on start edge
    step(0, 1, 0, 1, 5,   1, 1, 0, 5, "start_load5");
    step(0, 0, 0, 0, 0,   0, 0, 0, 5, "idle4");

    // reset mid-period with busy set
    step(0, 0, 0, 1, 4,   0, 0, 0, 4, "rb_load_idle");
    step(0, 1, 0, 0, 0,   1, 1, 0, 4, "rb_start");
    step(0, 1, 0, 1, 6,   1, 0, 1, 4, "rb_load6");
    step(1, 1, 0, 0, 0,   0, 0, 0, 2, "rb_reset");
    step(0, 1, 0, 0, 0,   1, 1, 0, 2, "rb_release");
    step(0, 1, 0, 0, 0,   0, 0, 0, 2, "rb_c1");

    begin
      int waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
        @(posedge clk_in);
        waited++;
      end
      #2;
      if (exp_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
